// File: rtl/noc_healer_pkg.sv
// Shared types and helpers for the multi-channel NoC SEU retry healer.
// HEALER_BACKOFF_EN adds the BACKOFF channel state.
package noc_healer_pkg;

  localparam int ERR_CNT_W = 16;

`ifdef HEALER_BACKOFF_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_BACKOFF,
    ST_FAIL
  } chan_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FAIL
  } chan_state_t;
`endif

  // Add that clamps at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                   input logic [ERR_CNT_W-1:0] b);
    logic [ERR_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/noc_heal_chan_fsm.sv
// Per-channel retry FSM: IDLE -> REQ -> WAIT, bounded retries, then FAIL until swap_done.
// Request is a level decoded from state; ack/done outside REQ/WAIT are ignored.
module noc_heal_chan_fsm
  import noc_healer_pkg::*;
#(
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 2
) (
  input  logic clk_1p6ghz,
  input  logic rst,
  input  logic parity_error,
  input  logic retry_ack,
  input  logic retry_done,
  input  logic retry_ok,
  input  logic swap_done,
  output logic retry_request,
  output logic in_fail
);

  localparam int RC_W = $clog2(MAX_RETRY + 1);

  chan_state_t     state, state_nxt;
  logic [RC_W-1:0] retry_cnt, retry_cnt_nxt;

`ifdef HEALER_BACKOFF_EN
  localparam int BO_W = $clog2(BACKOFF_CYC + 1);
  logic [BO_W-1:0] bo_cnt, bo_cnt_nxt;

  always_ff @(posedge clk_1p6ghz) begin
    if (rst) bo_cnt <= '0;
    else     bo_cnt <= bo_cnt_nxt;
  end
`else
  logic unused_backoff_cyc;
  assign unused_backoff_cyc = |BACKOFF_CYC;
`endif

  always_ff @(posedge clk_1p6ghz) begin
    if (rst) begin
      state     <= ST_IDLE;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    retry_cnt_nxt = retry_cnt;
`ifdef HEALER_BACKOFF_EN
    bo_cnt_nxt    = '0;
`endif
    case (state)
      ST_IDLE: if (parity_error) state_nxt = ST_REQ;
      ST_REQ:  if (retry_ack) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (retry_done) begin
          if (retry_ok) begin
            state_nxt     = ST_IDLE;
            retry_cnt_nxt = '0;
          end else if (retry_cnt == RC_W'(MAX_RETRY - 1)) begin
            state_nxt     = ST_FAIL;
            retry_cnt_nxt = RC_W'(MAX_RETRY);
          end else begin
            retry_cnt_nxt = retry_cnt + RC_W'(1);
`ifdef HEALER_BACKOFF_EN
            state_nxt     = ST_BACKOFF;
`else
            state_nxt     = ST_REQ;
`endif
          end
        end
      end
`ifdef HEALER_BACKOFF_EN
      // Dwell exactly BACKOFF_CYC cycles in BACKOFF before re-requesting.
      ST_BACKOFF: begin
        if (bo_cnt == BO_W'(BACKOFF_CYC - 1)) state_nxt = ST_REQ;
        else                                  bo_cnt_nxt = bo_cnt + BO_W'(1);
      end
`endif
      ST_FAIL: begin
        if (swap_done) begin
          state_nxt     = ST_IDLE;
          retry_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign retry_request = (state == ST_REQ);
  assign in_fail       = (state == ST_FAIL);

endmodule

// File: rtl/noc_seu_retry_healer.sv
// NoC SEU retry healer: per-channel veto/retry/failover, Ring 1 swap watchdog, error count.
// Veto is 1 cycle after the error; optional retry backoff via HEALER_BACKOFF_EN.
module noc_seu_retry_healer
  import noc_healer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int MAX_RETRY   = 3,
  parameter int BACKOFF_CYC = 2,
  parameter int SWAP_TMO    = 3
) (
  input  logic                 clk_1p6ghz,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    parity_error,
  input  logic [NUM_CH-1:0]    retry_ack,
  input  logic [NUM_CH-1:0]    retry_done,
  input  logic [NUM_CH-1:0]    retry_ok,
  input  logic                 swap_done,
  output logic [NUM_CH-1:0]    veto_pulse,
  output logic [NUM_CH-1:0]    retry_request,
  output logic                 swap_request,
  output logic [NUM_CH-1:0]    failover,
  output logic                 swap_timeout,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int WD_W = $clog2(SWAP_TMO + 1);

  logic [NUM_CH-1:0]    in_fail;
  logic [ERR_CNT_W-1:0] err_inc;
  logic [WD_W-1:0]      wd_cnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    noc_heal_chan_fsm #(
      .MAX_RETRY  (MAX_RETRY),
      .BACKOFF_CYC(BACKOFF_CYC)
    ) u_chan (
      .clk_1p6ghz   (clk_1p6ghz),
      .rst          (rst),
      .parity_error (parity_error[i]),
      .retry_ack    (retry_ack[i]),
      .retry_done   (retry_done[i]),
      .retry_ok     (retry_ok[i]),
      .swap_done    (swap_done),
      .retry_request(retry_request[i]),
      .in_fail      (in_fail[i])
    );
  end

  assign swap_request = |in_fail;

  always_comb begin
    err_inc = '0;
    for (int i = 0; i < NUM_CH; i++) err_inc = err_inc + ERR_CNT_W'(parity_error[i]);
  end

  always_ff @(posedge clk_1p6ghz) begin
    if (rst) begin
      veto_pulse   <= '0;
      err_count    <= '0;
      failover     <= '0;
      swap_timeout <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      veto_pulse <= parity_error;
      err_count  <= sat_add(err_count, err_inc);
      // Only channels already in FAIL are released; a same-cycle entrant stays put.
      if (swap_done) failover <= failover | in_fail;
      if (!swap_request || swap_done) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_W'(SWAP_TMO)) begin
        wd_cnt <= wd_cnt + WD_W'(1);
        if (wd_cnt == WD_W'(SWAP_TMO - 1)) swap_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_seu_retry_healer.sv
// Directed bench for noc_seu_retry_healer: vector table plus hand sequences.
// Expected backoff latency follows HEALER_BACKOFF_EN.
module tb_noc_seu_retry_healer;

  logic        clk_1p6ghz = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  parity_error = '0, retry_ack = '0, retry_done = '0, retry_ok = '0;
  logic        swap_done = 1'b0;
  logic [3:0]  veto_pulse, retry_request, failover;
  logic        swap_request, swap_timeout;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

`ifdef HEALER_BACKOFF_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  noc_seu_retry_healer #(
    .NUM_CH(4), .MAX_RETRY(3), .BACKOFF_CYC(2), .SWAP_TMO(3)
  ) dut (
    .clk_1p6ghz   (clk_1p6ghz),
    .rst          (rst),
    .parity_error (parity_error),
    .retry_ack    (retry_ack),
    .retry_done   (retry_done),
    .retry_ok     (retry_ok),
    .swap_done    (swap_done),
    .veto_pulse   (veto_pulse),
    .retry_request(retry_request),
    .swap_request (swap_request),
    .failover     (failover),
    .swap_timeout (swap_timeout),
    .err_count    (err_count)
  );

  always #5 clk_1p6ghz = ~clk_1p6ghz;

  typedef struct packed {
    logic        rst;
    logic [3:0]  perr, ack, done, ok;
    logic        sdone;
    logic [3:0]  e_veto, e_req;
    logic        e_swap;
    logic [3:0]  e_fo;
    logic        e_tmo;
    logic [15:0] e_err;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [3:0] pe, input logic [3:0] ak,
                      input logic [3:0] dn, input logic [3:0] ok, input logic sd);
    rst = r; parity_error = pe; retry_ack = ak; retry_done = dn; retry_ok = ok; swap_done = sd;
    @(posedge clk_1p6ghz);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  task automatic chk_all(input string nm, input logic [3:0] ev, input logic [3:0] er,
                         input logic es, input logic [3:0] ef, input logic et,
                         input logic [15:0] ee);
    chk({nm, ".veto"}, 16'(veto_pulse), 16'(ev));
    chk({nm, ".req"},  16'(retry_request), 16'(er));
    chk({nm, ".swap"}, 16'(swap_request), 16'(es));
    chk({nm, ".fo"},   16'(failover), 16'(ef));
    chk({nm, ".tmo"},  16'(swap_timeout), 16'(et));
    chk({nm, ".err"},  err_count, ee);
  endtask

  // Cycles from the retry_done edge until the request is seen again, bounded.
  task automatic wait_req(input logic [3:0] m, input string nm);
    int lat;
    lat = 1;
    while ((retry_request & m) != m && lat < 20) begin
      idle();
      lat++;
    end
    chk(nm, 16'(lat), 16'(EXP_LAT));
  endtask

  // Takes an IDLE channel through MAX_RETRY failed retries into FAIL.
  task automatic fail_chan(input int ch);
    logic [3:0] m;
    m = 4'(1 << ch);
    step(1'b0, m, 4'h0, 4'h0, 4'h0, 1'b0);
    chk($sformatf("fc%0d.req_rise", ch), 16'(retry_request[ch]), 16'd1);
    for (int r = 0; r < 3; r++) begin
      step(1'b0, 4'h0, m, 4'h0, 4'h0, 1'b0);
      idle();
      step(1'b0, 4'h0, 4'h0, m, 4'h0, 1'b0);
      if (r < 2) wait_req(m, $sformatf("fc%0d.relat%0d", ch, r));
    end
    chk($sformatf("fc%0d.swap", ch), 16'(swap_request), 16'd1);
    chk($sformatf("fc%0d.req_low", ch), 16'(retry_request[ch]), 16'd0);
  endtask

  initial begin
    //         rst   perr   ack    done   ok     sd    veto   req    swp   fo     tmo   err
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[6]  = '{1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[7]  = '{1'b0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0, 4'h3, 4'h3, 1'b0, 4'h0, 1'b0, 16'd3};
    tbl[8]  = '{1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0, 4'h2, 4'h3, 1'b0, 4'h0, 1'b0, 16'd4};
    tbl[9]  = '{1'b0, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd4};
    tbl[10] = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd0};
    tbl[11] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[12] = '{1'b0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 4'h0, 4'h1, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[13] = '{1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd1};
    tbl[15] = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 16'd2};
    tbl[16] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd0};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].perr, tbl[i].ack, tbl[i].done, tbl[i].ok, tbl[i].sdone);
      chk_all($sformatf("v%0d", i), tbl[i].e_veto, tbl[i].e_req, tbl[i].e_swap,
              tbl[i].e_fo, tbl[i].e_tmo, tbl[i].e_err);
    end

    // Ch2 exhausts its retries, swap_done two cycles after swap_request rises.
    do_reset();
    fail_chan(2);
    idle();
    chk("b.swap_hold", 16'(swap_request), 16'd1);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk_all("b.done", 4'h0, 4'h0, 1'b0, 4'h4, 1'b0, 16'd1);

    // Watchdog expiry with swap_done withheld.
    do_reset();
    fail_chan(1);
    chk("c.tmo0", 16'(swap_timeout), 16'd0);
    idle(); chk("c.tmo1", 16'(swap_timeout), 16'd0);
    idle(); chk("c.tmo2", 16'(swap_timeout), 16'd0);
    idle(); chk("c.tmo3", 16'(swap_timeout), 16'd1);
    idle(); idle();
    chk("c.swap_hold", 16'(swap_request), 16'd1);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk_all("c.done", 4'h0, 4'h0, 1'b0, 4'h2, 1'b1, 16'd1);

    // swap_done on the very cycle the watchdog reaches SWAP_TMO is on time.
    do_reset();
    fail_chan(0);
    idle(); idle();
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
    chk("c2.tmo", 16'(swap_timeout), 16'd0);
    chk("c2.fo", 16'(failover), 16'h1);

    // Ch3 enters FAIL on the swap_done cycle that releases ch0; then reset during FAIL.
    do_reset();
    step(1'b0, 4'h9, 4'h0, 4'h0, 4'h0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      step(1'b0, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0);
      idle();
      step(1'b0, 4'h0, 4'h0, 4'h9, 4'h0, 1'b0);
      wait_req(4'h9, $sformatf("d.relat%0d", r));
    end
    step(1'b0, 4'h0, 4'h9, 4'h0, 4'h0, 1'b0);
    idle();
    step(1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0);
    chk("d.swap_ch0", 16'(swap_request), 16'd1);
    step(1'b0, 4'h0, 4'h0, 4'h8, 4'h0, 1'b1);
    chk("d.fo_ch0", 16'(failover), 16'h1);
    chk("d.swap_ch3", 16'(swap_request), 16'd1);
    do_reset();
    chk_all("d.rst_fail", 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 16'd0);
    step(1'b0, 4'h8, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("d.restart_req", 16'(retry_request), 16'h8);
    step(1'b0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 4'h8, 4'h0, 1'b0);
    wait_req(4'h8, "d.restart_relat");
    chk("d.restart_swap", 16'(swap_request), 16'd0);

    // All channels erroring for three cycles: one retry each.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
      chk($sformatf("e.veto%0d", k), 16'(veto_pulse), 16'hF);
    end
    idle();
    chk_all("e.after", 4'h0, 4'hF, 1'b0, 4'h0, 1'b0, 16'd12);
    step(1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
    chk("e.ack", 16'(retry_request), 16'h0);
    idle();
    step(1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0);
    idle();
    chk("e.no_second", 16'(retry_request), 16'h0);

    // Saturation: 16383 x 4 + 2 = 16'hFFFE, then clamp.
    do_reset();
    for (int k = 0; k < 16383; k++) step(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("g.fffe", err_count, 16'hFFFE);
    step(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("g.sat", err_count, 16'hFFFF);
    step(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("g.sat_hold", err_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
